branch_condition_comparator: RTL

- Parametrised, pipelined successor to the team's 32-bit combinational inequality comparator.
- Evaluates one of eight MIPS branch conditions (EQ, NE, signed/unsigned less-than, and the four compare-with-zero forms) on WIDTH-bit operands.
- Two-stage valid/ready pipeline carrying a caller tag; sits between register-read and the branch-resolution logic.
- Keeps a saturating count of true results for performance monitoring.

---
 rtl/branch_condition_comparator.sv | 109 ++++++++++
 1 files changed

// File: rtl/branch_condition_comparator.sv
// Branch condition comparator: evaluates one of eight MIPS branch conditions on tagged requests.
// Latency: 2 cycles from input transfer to out_valid (capture stage, then evaluate-and-register stage).
// Backpressure: outputs hold while out_valid && !out_ready; once stage 1 fills, in_ready follows out_ready.
module branch_condition_comparator #(
   parameter int WIDTH       = 32,
   parameter int TAG_WIDTH   = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       input_a,
   input  logic [WIDTH-1:0]       input_b,
   input  logic [2:0]             compare_mode,
   input  logic [TAG_WIDTH-1:0]   input_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   condition_true,
   output logic [TAG_WIDTH-1:0]   output_tag,
   output logic [COUNT_WIDTH-1:0] true_count
);

   localparam logic [2:0] MODE_EQ  = 3'd0;
   localparam logic [2:0] MODE_NE  = 3'd1;
   localparam logic [2:0] MODE_LT  = 3'd2;
   localparam logic [2:0] MODE_LTU = 3'd3;
   localparam logic [2:0] MODE_GEZ = 3'd4;
   localparam logic [2:0] MODE_LTZ = 3'd5;
   localparam logic [2:0] MODE_GTZ = 3'd6;
   localparam logic [2:0] MODE_LEZ = 3'd7;

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

   logic                 stage1_valid;
   logic [WIDTH-1:0]     stage1_a;
   logic [WIDTH-1:0]     stage1_b;
   logic [2:0]           stage1_mode;
   logic [TAG_WIDTH-1:0] stage1_tag;

   logic stage2_free;
   logic in_transfer;
   logic out_transfer;
   logic a_negative;
   logic a_zero;
   logic evaluated;

   // Stage 2 can take a new entry when it is empty or its result leaves this cycle.
   assign stage2_free  = !out_valid || out_ready;
   assign in_ready     = !stage1_valid || stage2_free;
   assign in_transfer  = in_valid && in_ready;
   assign out_transfer = out_valid && out_ready;

   // Evaluate the selected condition on the stage-1 operands; B is ignored by the zero-compare modes.
   always_comb begin
      a_negative = stage1_a[WIDTH-1];
      a_zero     = (stage1_a == '0);
      evaluated  = 1'b0;
      case (stage1_mode)
         MODE_EQ:  evaluated = (stage1_a == stage1_b);
         MODE_NE:  evaluated = |(stage1_a ^ stage1_b);
         MODE_LT:  evaluated = ($signed(stage1_a) < $signed(stage1_b));
         MODE_LTU: evaluated = (stage1_a < stage1_b);
         MODE_GEZ: evaluated = !a_negative;
         MODE_LTZ: evaluated = a_negative;
         MODE_GTZ: evaluated = !a_negative && !a_zero;
         MODE_LEZ: evaluated = a_negative || a_zero;
         default:  evaluated = 1'b0;
      endcase
   end

   // Stage 1: capture the request on input transfer; empty out when it advances with nothing behind it.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         stage1_valid <= 1'b0;
      end else if (in_transfer) begin
         stage1_valid <= 1'b1;
         stage1_a     <= input_a;
         stage1_b     <= input_b;
         stage1_mode  <= compare_mode;
         stage1_tag   <= input_tag;
      end else if (stage2_free) begin
         stage1_valid <= 1'b0;
      end
   end

   // Stage 2: register the evaluated result whenever it is free; hold stable while stalled.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         out_valid      <= 1'b0;
         condition_true <= 1'b0;
         output_tag     <= '0;
      end else if (stage2_free) begin
         out_valid      <= stage1_valid;
         condition_true <= stage1_valid && evaluated;
         output_tag     <= stage1_tag;
      end
   end

   // Count delivered true results, sticking at all-ones instead of wrapping.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         true_count <= '0;
      end else if (out_transfer && condition_true && (true_count != COUNT_MAX)) begin
         true_count <= true_count + COUNT_WIDTH'(1);
      end
   end

endmodule
